rng_stream_source: RTL and testbench

Stimulus source for the on-chip randomness tests: it emits a serial pseudo-random bit stream on the epsilon line, one bit per clock, framed into fixed-length test sequences. After each sequence it waits for the tester's `valid`/`is_random` verdict and tallies the passes and fails. It sits at the opposite end of the epsilon/verdict interface from the test core, so a run can be self-checked on silicon without external pattern generation.

---
 rtl/rng_src_pkg.sv | 32 +++
 rtl/rng_lfsr16.sv | 24 ++
 rtl/rng_stream_source.sv | 122 ++++++++++++
 tb/tb_rng_stream_source.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_src_pkg.sv
// Shared types and constants for the pseudo-random epsilon stream source.
// Includes the 16-bit Fibonacci LFSR recurrence and a saturating tally helper.
package rng_src_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    FIN    = 2'd3
  } state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Taps of x^16 + x^14 + x^13 + x^11 + 1, MSB is the streamed bit
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  localparam int CNT_W      = 8;
  localparam int SEQ_LEFT_W = 9;
  localparam int BIT_CNT_W  = 16;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/rng_lfsr16.sv
// 16-bit LFSR with synchronous load and step; a zero seed would lock up,
// so it is replaced by the default seed on load.
module rng_lfsr16
  import rng_src_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DEFAULT_SEED;
    end else if (load) begin
      state <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/rng_stream_source.sv
// Streams framed pseudo-random sequences on epsilon_out and tallies the
// tester's per-sequence verdicts, aborting the run on a verdict timeout.
module rng_stream_source
  import rng_src_pkg::*;
#(
  parameter int SEQ_LEN = 128,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      seed,
  input  logic [7:0]       num_seq,
  input  logic             bias_en,
  output logic             epsilon_out,
  input  logic             valid_in,
  input  logic             is_random_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             timeout_err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(SEQ_LEN - 1);
  localparam logic [WAIT_W-1:0]    LAST_WAIT = WAIT_W'(TIMEOUT - 1);

  state_t                 state;
  logic                   bias;
  logic [SEQ_LEFT_W-1:0]  seq_left;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [15:0]            lfsr_state;
  logic                   lfsr_load;
  logic                   lfsr_step;

  assign lfsr_load = (state == IDLE) && start;
  assign lfsr_step = (state == STREAM);

  rng_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  // Only the MSB is streamed; the lower bits exist solely as LFSR history
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^lfsr_state[14:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bias        <= 1'b0;
      seq_left    <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      epsilon_out <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      done        <= 1'b0;
      epsilon_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bias        <= bias_en;
            seq_left    <= (num_seq == 8'd0) ? SEQ_LEFT_W'(256) : {1'b0, num_seq};
            bit_cnt     <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            state       <= STREAM;
          end
        end
        STREAM: begin
          epsilon_out <= bias ? 1'b1 : lfsr_state[TAP_A];
          if (bit_cnt == LAST_BIT) begin
            bit_cnt  <= '0;
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WAIT: begin
          // A verdict on the final timeout cycle still wins over the abort
          if (valid_in) begin
            if (is_random_in) pass_cnt <= sat_inc(pass_cnt);
            else              fail_cnt <= sat_inc(fail_cnt);
            seq_left <= seq_left - 1'b1;
            if (seq_left == SEQ_LEFT_W'(1)) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              state <= STREAM;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= FIN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_stream_source.sv
// Randomized self-checking bench for rng_stream_source; the expected stream
// comes from the bit-level recurrence s[n+16] = s[n]^s[n+2]^s[n+3]^s[n+5].
module tb_rng_stream_source;

  localparam int SEQ_LEN = 16;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  logic [7:0]  num_seq = '0;
  logic        bias_en = 1'b0;
  logic        valid_in = 1'b0;
  logic        is_random_in = 1'b0;
  logic        epsilon_out, busy, done, timeout_err;
  logic [7:0]  pass_cnt, fail_cnt;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          ref_bits[$];
  bit          verdict_q[$];
  int          delay_q[$];
  logic [15:0] first16;

  always #5 clk = ~clk;

  rng_stream_source #(.SEQ_LEN(SEQ_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .seed         (seed),
    .num_seq      (num_seq),
    .bias_en      (bias_en),
    .epsilon_out  (epsilon_out),
    .valid_in     (valid_in),
    .is_random_in (is_random_in),
    .busy         (busy),
    .done         (done),
    .pass_cnt     (pass_cnt),
    .fail_cnt     (fail_cnt),
    .timeout_err  (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat255(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  // Unbiased reference stream for the current run, grown on demand
  function automatic bit ref_bit(input int n);
    while (ref_bits.size() <= n) begin
      int k;
      k = ref_bits.size() - 16;
      ref_bits.push_back(ref_bits[k] ^ ref_bits[k+2] ^ ref_bits[k+3] ^ ref_bits[k+5]);
    end
    return ref_bits[n];
  endfunction

  task automatic set_verdicts(input int n, input int mode, input int max_delay);
    verdict_q.delete();
    delay_q.delete();
    for (int i = 0; i < n; i++) begin
      verdict_q.push_back((mode == 1) ? 1'b1 : 1'($urandom));
      delay_q.push_back(int'($urandom_range(max_delay, 0)));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_eps"}, epsilon_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass_cnt, 0);
    chk({tag, "_fail"}, fail_cnt, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
  endtask

  // One full run; abort_seq >= 0 pulls rst_n low during bit 5 of that sequence
  task automatic run(input logic [15:0] sd, input logic [7:0] ns, input logic bs,
                     input int abort_seq, input int glitch_seq);
    int total;
    int pos;
    int exp_pass;
    int exp_fail;
    logic [15:0] s0;
    total    = (ns == 0) ? 256 : int'(ns);
    pos      = 0;
    exp_pass = 0;
    exp_fail = 0;
    s0 = (sd == 16'h0) ? 16'hACE1 : sd;
    ref_bits.delete();
    for (int i = 15; i >= 0; i--) ref_bits.push_back(s0[i]);

    @(negedge clk);
    seed = sd; num_seq = ns; bias_en = bs; start = 1'b1;
    @(negedge clk);
    start = 1'b0; seed = 16'($urandom); num_seq = 8'($urandom); bias_en = 1'($urandom);
    chk("busy_after_start", busy, 1);

    for (int s = 0; s < total; s++) begin
      int d;
      bit v;
      for (int b = 0; b < SEQ_LEN; b++) begin
        @(negedge clk);
        chk("stream_bit", epsilon_out, bs ? 1'b1 : ref_bit(pos));
        pos++;
        if (s == 0) first16[15-b] = epsilon_out;
        if (s == abort_seq && b == 5) begin
          #2 rst_n = 1'b0;
          #1 check_reset_outputs("async_rst");
          valid_in = 1'b0;
          start = 1'b0;
          return;
        end
        start = (s == glitch_seq && b == 3);
        // Verdicts before the first WAIT cycle must be ignored
        valid_in = (b < SEQ_LEN - 1) ? 1'($urandom) : 1'b0;
        is_random_in = 1'($urandom);
      end
      d = delay_q[s];
      v = verdict_q[s];
      if (d > 0) begin
        @(negedge clk);
        chk("eps_low_in_wait", epsilon_out, 0);
        chk("busy_in_wait", busy, 1);
        repeat (d - 1) @(negedge clk);
      end
      valid_in = 1'b1;
      is_random_in = v;
      @(negedge clk);
      valid_in = 1'b0;
      is_random_in = 1'($urandom);
      if (v) exp_pass++;
      else   exp_fail++;
      chk("pass_running", pass_cnt, sat255(exp_pass));
      chk("fail_running", fail_cnt, sat255(exp_fail));
    end
    chk("done_pulse", done, 1);
    chk("busy_in_fin", busy, 1);
    @(negedge clk);
    chk("done_low", done, 0);
    chk("busy_low", busy, 0);
    chk("pass_cnt", pass_cnt, sat255(exp_pass));
    chk("fail_cnt", fail_cnt, sat255(exp_fail));
    chk("timeout_err", timeout_err, 0);
    $display("run seed=%h num_seq=%0d bias=%0d: pass=%0d fail=%0d", sd, total, bs, pass_cnt, fail_cnt);
  endtask

  task automatic run_timeout(input logic [15:0] sd);
    int cyc;
    ref_bits.delete();
    for (int i = 15; i >= 0; i--) ref_bits.push_back(sd[i]);
    @(negedge clk);
    seed = sd; num_seq = 8'd1; bias_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < SEQ_LEN; b++) begin
      @(negedge clk);
      chk("tmo_stream_bit", epsilon_out, ref_bit(b));
    end
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == TIMEOUT - 1) chk("tmo_not_early", timeout_err, 0);
      if (done) break;
    end
    chk("tmo_wait_cycles", cyc, TIMEOUT);
    chk("tmo_err_set", timeout_err, 1);
    chk("tmo_pass", pass_cnt, 0);
    chk("tmo_fail", fail_cnt, 0);
    @(negedge clk);
    chk("tmo_busy_low", busy, 0);
    chk("tmo_done_low", done, 0);
    valid_in = 1'b1;
    is_random_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    chk("idle_valid_pass", pass_cnt, 0);
    chk("idle_valid_fail", fail_cnt, 0);
    chk("idle_valid_busy", busy, 0);
    chk("tmo_err_held", timeout_err, 1);
    $display("timeout run seed=%h: waited %0d cycles, timeout_err=%0d", sd, cyc, timeout_err);
  endtask

  initial begin
    logic [15:0] rseed;
    logic [15:0] seed_stream;
    seed_stream = 16'b1010110011100001;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Documented seed stream with a verdict three cycles into WAIT
    verdict_q.delete(); delay_q.delete();
    verdict_q.push_back(1'b1); delay_q.push_back(3);
    run(16'hACE1, 8'd1, 1'b0, -1, -1);
    chk("seed_stream", first16, seed_stream);

    // Zero seed behaves like the default seed
    run(16'h0000, 8'd1, 1'b0, -1, -1);
    chk("zero_seed_stream", first16, seed_stream);

    // Biased run, then the same seed unbiased to check LFSR continuation
    rseed = 16'($urandom_range(65535, 1));
    verdict_q.delete(); delay_q.delete();
    verdict_q.push_back(1'b0); verdict_q.push_back(1'b0); verdict_q.push_back(1'b1);
    for (int i = 0; i < 3; i++) delay_q.push_back(int'($urandom_range(6, 0)));
    run(rseed, 8'd3, 1'b1, -1, -1);
    set_verdicts(3, 0, 6);
    run(rseed, 8'd3, 1'b0, -1, -1);

    for (int r = 0; r < 6; r++) begin
      logic [7:0] ns;
      ns = 8'($urandom_range(4, 1));
      set_verdicts(int'(ns), 0, 6);
      run(16'($urandom), ns, 1'($urandom), -1, -1);
    end

    run_timeout(16'($urandom_range(65535, 1)));

    // 256 sequences, saturating pass count, stray start mid-run
    set_verdicts(256, 1, 0);
    run(16'($urandom), 8'd0, 1'b0, -1, 5);

    // Asynchronous reset mid-run, then the seed stream restarts from bit 0
    set_verdicts(2, 1, 2);
    run(16'hACE1, 8'd2, 1'b0, 1, -1);
    @(negedge clk);
    check_reset_outputs("held_rst");
    rst_n = 1'b1;
    set_verdicts(1, 0, 2);
    run(16'hACE1, 8'd1, 1'b0, -1, -1);
    chk("post_reset_stream", first16, seed_stream);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
